// File: rtl/ecc_mm_result_collect.sv
// Result collector for the Montgomery multiplier PE array: buffers the word-serial
// product, subtracts p word by word, and presents the reduced result with a ready pulse.
module ecc_mm_result_collect #(
  parameter int RADIX    = 32,
  parameter int REG_SIZE = 384,
  parameter int S_NUM    = REG_SIZE / RADIX + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                zeroize,
  input  logic                start_i,
  input  logic                s_valid_i,
  input  logic [RADIX-1:0]    s_word_i,
  input  logic [REG_SIZE-1:0] p_i,
  output logic                busy_o,
  output logic                ready_o,
  output logic [REG_SIZE-1:0] result_o
);

  localparam int CNT_W = $clog2(S_NUM + 1);
  localparam int BUF_W = S_NUM * RADIX;
  localparam int SUB_W = RADIX + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(S_NUM - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                borrow_q;
  logic [BUF_W-1:0]    s_buf_q;
  logic [BUF_W-1:0]    diff_buf_q;
  logic                busy_q;
  logic                ready_q;
  logic [REG_SIZE-1:0] result_q;

  logic [BUF_W-1:0]    p_ext_s;
  logic [RADIX-1:0]    p_word_s;
  logic [SUB_W-1:0]    sub_s;

  // Word k of the modulus (zero for the overflow word) and the single borrow-chained subtractor.
  always_comb begin
    p_ext_s  = BUF_W'(p_i);
    p_word_s = p_ext_s[int'(cnt_q) * RADIX +: RADIX];
    sub_s    = {1'b0, s_word_i} - {1'b0, p_word_s} - SUB_W'(borrow_q);
  end

  // Collection FSM with registered outputs; the DONE cycle picks s or s-p by the final borrow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      s_buf_q    <= '0;
      diff_buf_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      result_q   <= '0;
    end else if (zeroize) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      s_buf_q    <= '0;
      diff_buf_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      if (state_q == DONE) begin
        ready_q  <= 1'b1;
        result_q <= borrow_q ? s_buf_q[REG_SIZE-1:0] : diff_buf_q[REG_SIZE-1:0];
      end else begin
        result_q <= result_q;
      end

      // start_i wins over any word arriving in the same cycle.
      if (start_i) begin
        state_q    <= COLLECT;
        cnt_q      <= '0;
        borrow_q   <= 1'b0;
        s_buf_q    <= '0;
        diff_buf_q <= '0;
        busy_q     <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          COLLECT: begin
            if (s_valid_i) begin
              s_buf_q[int'(cnt_q) * RADIX +: RADIX]    <= s_word_i;
              diff_buf_q[int'(cnt_q) * RADIX +: RADIX] <= sub_s[RADIX-1:0];
              borrow_q <= sub_s[RADIX];
              cnt_q    <= cnt_q + CNT_W'(1);
              if (cnt_q == LAST_CNT) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= COLLECT;
                busy_q  <= 1'b1;
              end
            end else begin
              state_q <= COLLECT;
              busy_q  <= 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o   = busy_q;
  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_ecc_mm_result_collect.sv
// Directed bench for ecc_mm_result_collect (RADIX=32, REG_SIZE=64, p=0xFFFFFFFF_00000001);
// expected results are queued at stimulus time and popped when ready_o pulses.
`timescale 1ns/1ps
module tb_ecc_mm_result_collect;

  localparam int RADIX    = 32;
  localparam int REG_SIZE = 64;
  localparam int S_NUM    = 3;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                zeroize = 1'b0;
  logic                start_i = 1'b0;
  logic                s_valid_i = 1'b0;
  logic [RADIX-1:0]    s_word_i = '0;
  logic [REG_SIZE-1:0] p_i = 64'hFFFF_FFFF_0000_0001;
  logic                busy_o;
  logic                ready_o;
  logic [REG_SIZE-1:0] result_o;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  logic [63:0] sb_q[$];

  ecc_mm_result_collect #(
    .RADIX(RADIX), .REG_SIZE(REG_SIZE), .S_NUM(S_NUM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start_i(start_i),
    .s_valid_i(s_valid_i), .s_word_i(s_word_i), .p_i(p_i),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready_o === 1'b1) ready_cnt <= ready_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
  endtask

  task automatic send(input logic [31:0] w);
    s_valid_i = 1'b1;
    s_word_i  = w;
    tick();
    s_valid_i = 1'b0;
    s_word_i  = 32'h0;
  endtask

  task automatic gaps(input int maxgap);
    int n;
    if (maxgap > 0) begin
      n = $urandom_range(1, maxgap);
      for (int i = 0; i < n; i++) begin
        tick();
        chk("busy_in_gap", 64'(busy_o), 64'd1);
      end
    end
  endtask

  task automatic run_txn(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [63:0] exp, input int maxgap, input bit do_start);
    logic [63:0] e;
    if (do_start) pulse_start();
    sb_q.push_back(exp);
    send(w0);
    gaps(maxgap);
    send(w1);
    gaps(maxgap);
    send(w2);
    chk("done_ready_low", 64'(ready_o), 64'd0);
    chk("done_busy_low", 64'(busy_o), 64'd0);
    tick();
    chk("ready_pulse", 64'(ready_o), 64'd1);
    chk("ready_busy_low", 64'(busy_o), 64'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("result", result_o, e);
      tick();
      chk("ready_one_cycle", 64'(ready_o), 64'd0);
      chk("result_hold", result_o, e);
    end
  endtask

  initial begin
    int rc0;
    #12;
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    reset_n = 1'b1;
    tick();

    // Scenario 1: s < p, final borrow set.
    run_txn(32'h5, 32'h0, 32'h0, 64'h0000_0000_0000_0005, 0, 1'b1);
    // Scenario 2: s = p+3.
    run_txn(32'h4, 32'hFFFF_FFFF, 32'h0, 64'h0000_0000_0000_0003, 0, 1'b1);
    // Scenario 3: s = 2p-1 with overflow word.
    run_txn(32'h1, 32'hFFFF_FFFE, 32'h1, 64'hFFFF_FFFF_0000_0000, 0, 1'b1);
    // Scenario 4: s = p, then scenario 2 with gaps.
    run_txn(32'h1, 32'hFFFF_FFFF, 32'h0, 64'h0, 0, 1'b1);
    run_txn(32'h4, 32'hFFFF_FFFF, 32'h0, 64'h0000_0000_0000_0003, 2, 1'b1);

    // Scenario 5: aborts, then a start coincident with a dropped word.
    rc0 = ready_cnt;
    pulse_start();
    send(32'h1);
    send(32'hFFFF_FFFE);
    pulse_start();
    start_i   = 1'b1;
    s_valid_i = 1'b1;
    s_word_i  = 32'hDEAD_BEEF;
    tick();
    start_i   = 1'b0;
    s_valid_i = 1'b0;
    chk("busy_after_coincident", 64'(busy_o), 64'd1);
    run_txn(32'h5, 32'h0, 32'h0, 64'h0000_0000_0000_0005, 0, 1'b0);
    chk("abort_single_ready", 64'(ready_cnt - rc0), 64'd1);

    // Scenario 6a: asynchronous reset mid-collection.
    pulse_start();
    send(32'h7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy_o), 64'd0);
    chk("async_rst_ready", 64'(ready_o), 64'd0);
    chk("async_rst_result", result_o, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    rc0 = ready_cnt;
    send(32'h5);
    send(32'h0);
    send(32'h0);
    tick();
    tick();
    chk("no_start_no_ready", 64'(ready_cnt - rc0), 64'd0);
    chk("no_start_busy", 64'(busy_o), 64'd0);

    // Scenario 6b: synchronous zeroize mid-collection.
    run_txn(32'h4, 32'hFFFF_FFFF, 32'h0, 64'h0000_0000_0000_0003, 0, 1'b1);
    pulse_start();
    send(32'h9);
    zeroize = 1'b1;
    #2;
    chk("zeroize_sync_hold", result_o, 64'h3);
    tick();
    zeroize = 1'b0;
    chk("zeroize_busy", 64'(busy_o), 64'd0);
    chk("zeroize_ready", 64'(ready_o), 64'd0);
    chk("zeroize_result", result_o, 64'd0);
    rc0 = ready_cnt;
    send(32'h1);
    send(32'h1);
    send(32'h0);
    tick();
    tick();
    chk("zeroize_idle_no_ready", 64'(ready_cnt - rc0), 64'd0);
    run_txn(32'h5, 32'h0, 32'h0, 64'h0000_0000_0000_0005, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_mm_result_collect.md
Name: ecc_mm_result_collect

Overview:
- Downstream stage of the Montgomery multiplier PE array.
- Collects the word-serial Montgomery product (LSW first) emitted by the last PE.
- Performs the final conditional subtraction word-serially, using a registered borrow chain.
- Presents the fully reduced REG_SIZE-bit result (< p) with a one-cycle ready pulse to the ECC arithmetic unit.

Parameters:
- RADIX, 32, word width; must match the PE array.
- REG_SIZE, 384, operand/modulus width; must be a multiple of RADIX.
- S_NUM, REG_SIZE/RADIX + 1, number of product words accepted, including the top overflow word.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- zeroize  input  1  synchronous clear of all state and outputs
- start_i  input  1  pulse; begins a new collection and aborts any in progress
- s_valid_i  input  1  s_word_i is valid this cycle
- s_word_i  input  RADIX  product word from the PE array, LSW first
- p_i  input  REG_SIZE  modulus; stable from start_i until ready_o
- busy_o  output  1  high while collecting
- ready_o  output  1  one-cycle pulse; result_o valid
- result_o  output  REG_SIZE  reduced product

Behaviour:
- Reset (reset_n low, asynchronous) and zeroize (synchronous) produce the same state:
  - FSM = IDLE
  - word counter = 0, borrow = 0
  - s buffer = 0, diff buffer = 0
  - busy_o = 0, ready_o = 0, result_o = 0
- State IDLE:
  - start_i → COLLECT.
  - Counter, borrow, s buffer and diff buffer are cleared in the same cycle.
  - s_valid_i is ignored.
- State COLLECT:
  - busy_o = 1.
  - On each s_valid_i at counter k:
    - s buffer word k ← s_word_i.
    - {borrow_next, diff_k} = s_word_i − pw_k − borrow, computed at RADIX+1 bits, where pw_k = p_i[k*RADIX +: RADIX] for k < S_NUM−1 and pw_k = 0 for k = S_NUM−1.
    - diff buffer word k ← diff_k; borrow ← borrow_next; counter increments.
  - Gaps in s_valid_i are allowed: without s_valid_i, the counter and borrow hold.
  - When the word with k = S_NUM−1 is accepted → DONE on the next edge.
- State DONE (exactly one cycle):
  - ready_o = 1, busy_o = 0.
  - result_o ← lower REG_SIZE bits of the diff buffer if final borrow = 0 (s ≥ p); otherwise lower REG_SIZE bits of the s buffer.
  - Next state is IDLE.
- Latency: result_o/ready_o update on the clock edge after the edge that accepted the last word, i.e. one cycle after the final s_valid_i.
- result_o holds its value until the next DONE, reset, or zeroize. It is not cleared by start_i.
- Input range: s < 2p is guaranteed upstream, so the top word is 0 or 1. If s ≥ 2p, behaviour is undefined; no checking is done.
- Simultaneous events:
  - start_i in COLLECT or DONE restarts at counter 0 and drops any partial data. In DONE, ready_o still pulses that cycle.
  - start_i and s_valid_i in the same cycle: start_i wins and the word is dropped.
  - zeroize overrides start_i.
  - s_valid_i in DONE or IDLE is ignored.
- Counter width: clog2(S_NUM+1). The counter never wraps; COLLECT exits at S_NUM−1.
- Arithmetic: no DSP use; one RADIX+1-bit subtractor only.

Test Plan (RADIX=32, REG_SIZE=64, S_NUM=3, p=0xFFFFFFFF_00000001):
1. start_i, then words 0x00000005, 0x00000000, 0x00000000 back-to-back → borrow=1; ready_o pulses one cycle after the third word; result_o = 0x00000000_00000005.
2. Words 0x00000004, 0xFFFFFFFF, 0x00000000 (s = p+3) → borrow=0; result_o = 0x00000000_00000003.
3. Words 0x00000001, 0xFFFFFFFE, 0x00000001 (s = 2p−1, overflow word set) → result_o = 0xFFFFFFFF_00000000.
4. Words 0x00000001, 0xFFFFFFFF, 0x00000000 (s = p) → result_o = 0; then random 2-cycle gaps between words of scenario 2 → same result 3, with ready_o delayed accordingly and busy_o high throughout.
5. start_i after two words of scenario 3, then start_i coincident with a word (word dropped), then scenario 1 words → result_o = 5, exactly one ready_o pulse.
6. reset_n low mid-COLLECT (after one word) → all outputs 0 immediately (asynchronous), FSM in IDLE; s_valid_i without start_i produces no ready_o. Repeat with zeroize → outputs 0 on the next edge.
